// File: rtl/qam_fifo_arb_ctrl_if.sv
// -----------------------------------------------------------------------------
// qam_fifo_arb_ctrl_if
//   Signal bundle between the QAM symbol FIFO controller, its two producers,
//   its consumer and the external fifo_mem instance.
//
//   Parameters : DATA_W symbol width, ADDR_W memory index width,
//                PTR_W pointer width presented to the memory (>= ADDR_W+1).
//   Modports   : slave  - the controller (qam_fifo_arb_ctrl)
//                master - the surrounding logic (producers, consumer, memory)
//   Groups     : req0_* / req1_* producer handshakes, pop/pop_valid consumer
//                handshake, mem_* memory port controls, full/empty/level/owner
//                status.
//   Optional   : QAM_FIFO_ERR_FLAG_EN adds err_clr, ovf_err and udf_err.
// -----------------------------------------------------------------------------
interface qam_fifo_arb_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int PTR_W  = 4
);
  // Producer 0
  logic              req0_valid;
  logic              req0_last;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  // Producer 1
  logic              req1_valid;
  logic              req1_last;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  // Consumer
  logic              pop;
  logic              pop_valid;
  // Memory port controls
  logic              mem_wr_en;
  logic [PTR_W-1:0]  mem_wr_ptr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_rd_en;
  logic [PTR_W-1:0]  mem_rd_ptr;
  // Status
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic [1:0]        owner;
`ifdef QAM_FIFO_ERR_FLAG_EN
  logic              err_clr;
  logic              ovf_err;
  logic              udf_err;
`endif

  modport slave (
    input  req0_valid, req0_last, req0_data,
    input  req1_valid, req1_last, req1_data,
    input  pop,
`ifdef QAM_FIFO_ERR_FLAG_EN
    input  err_clr,
    output ovf_err, udf_err,
`endif
    output req0_ready, req1_ready,
    output pop_valid,
    output mem_wr_en, mem_wr_ptr, mem_wr_data,
    output mem_rd_en, mem_rd_ptr,
    output full, empty, level, owner
  );

  modport master (
    output req0_valid, req0_last, req0_data,
    output req1_valid, req1_last, req1_data,
    output pop,
`ifdef QAM_FIFO_ERR_FLAG_EN
    output err_clr,
    input  ovf_err, udf_err,
`endif
    input  req0_ready, req1_ready,
    input  pop_valid,
    input  mem_wr_en, mem_wr_ptr, mem_wr_data,
    input  mem_rd_en, mem_rd_ptr,
    input  full, empty, level, owner
  );
endinterface : qam_fifo_arb_ctrl_if

// File: rtl/qam_fifo_arb_ctrl.sv
// -----------------------------------------------------------------------------
// qam_fifo_arb_ctrl
//   Controller for the 4-entry symbol FIFO (fifo_mem) of the QAM datapath.
//   - Shares the memory write port between two producers with round-robin,
//     burst-locked arbitration (IDLE / OWN0 / OWN1).
//   - Owns the write/read pointers and derives full, empty and level.
//   - Issues the read enable for an accepted pop and flags pop_valid one cycle
//     later, aligned with the memory's registered data_out.
//   The memory itself lives outside this block.
//
//   Ports:
//     clk    - single clock, all state on posedge
//     rst_n  - asynchronous active-low reset
//     fifo_if (qam_fifo_arb_ctrl_if.slave) - producer, consumer, memory and
//            status signals.
//
//   Optional feature macro: QAM_FIFO_ERR_FLAG_EN
//     When defined, sticky overflow / underflow flags are added (ovf_err,
//     udf_err) with a clear input (err_clr). When undefined those signals do
//     not exist and no error state is built.
// -----------------------------------------------------------------------------
module qam_fifo_arb_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int PTR_W  = 4   // must be >= ADDR_W+1; extra upper bits read as 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  qam_fifo_arb_ctrl_if.slave     fifo_if
);

  typedef logic [ADDR_W:0] ptr_t;  // index bits plus one wrap bit

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   rr_last_q, rr_last_d;   // 1: producer 1 won the last IDLE pick
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  logic   pop_valid_q, pop_valid_d;

  // ---------------------------------------------------------------------------
  // Status from current-state pointers only, so a same-cycle pop never makes
  // room for a push and a same-cycle push never feeds a pop.
  // ---------------------------------------------------------------------------
  logic full, empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W]     != rd_ptr_q[ADDR_W]);

  // ---------------------------------------------------------------------------
  // Arbitration and handshake
  // ---------------------------------------------------------------------------
  logic [1:0]        valid_vec;
  logic [1:0]        grant;       // one-hot {req1,req0}; also the owner output
  logic [1:0]        ready;
  logic              push;
  logic              push_last;
  logic              pop_acc;
  logic [DATA_W-1:0] wr_data;

  assign valid_vec = {fifo_if.req1_valid, fifo_if.req0_valid};

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    grant     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Round-robin only matters on contention: the producer that did not
        // win last time takes the pick.
        if (valid_vec == 2'b11) begin
          grant = rr_last_q ? 2'b01 : 2'b10;
        end else if (valid_vec[0]) begin
          grant = 2'b01;
        end else if (valid_vec[1]) begin
          grant = 2'b10;
        end
      end
      // A locked owner keeps the grant even while its valid is low.
      ST_OWN0: grant = 2'b01;
      ST_OWN1: grant = 2'b10;
      default: grant = 2'b00;
    endcase

    ready     = grant & {2{~full}};
    push      = |(ready & valid_vec);
    push_last = grant[1] ? fifo_if.req1_last : fifo_if.req0_last;
    wr_data   = grant[1] ? fifo_if.req1_data : fifo_if.req0_data;

    if (push) begin
      case (state_q)
        ST_IDLE: begin
          rr_last_d = grant[1];
          // A single-beat burst (last on its first beat) never locks.
          if (!push_last) begin
            state_d = grant[1] ? ST_OWN1 : ST_OWN0;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (push_last) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pop acceptance depends only on pop and the registered pointers; it has no
  // path into the producer ready signals.
  assign pop_acc     = fifo_if.pop && !empty;
  assign wr_ptr_d    = push    ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
  assign rd_ptr_d    = pop_acc ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
  assign pop_valid_d = pop_acc;

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b1;      // producer 0 wins the first contention
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The memory array is outside this block; its contents are never
  // cleared, and resetting the pointers is what discards buffered entries.
  // ---------------------------------------------------------------------------
  assign fifo_if.req0_ready  = ready[0];
  assign fifo_if.req1_ready  = ready[1];
  assign fifo_if.owner       = grant;
  assign fifo_if.mem_wr_en   = push;
  assign fifo_if.mem_wr_data = wr_data;
  assign fifo_if.mem_wr_ptr  = PTR_W'(wr_ptr_q);
  assign fifo_if.mem_rd_en   = pop_acc;
  assign fifo_if.mem_rd_ptr  = PTR_W'(rd_ptr_q);
  assign fifo_if.pop_valid   = pop_valid_q;
  assign fifo_if.full        = full;
  assign fifo_if.empty       = empty;
  assign fifo_if.level       = wr_ptr_q - rd_ptr_q;   // modulo 2**(ADDR_W+1)

`ifdef QAM_FIFO_ERR_FLAG_EN
  // ---------------------------------------------------------------------------
  // Sticky error flags. Overflow: the granted (owning or picked) producer
  // presents a beat while full. Underflow: a pop while empty. A set in the
  // same cycle as err_clr wins.
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_set, udf_set;

  assign ovf_set = full && |(grant & valid_vec);
  assign udf_set = fifo_if.pop && empty;

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (fifo_if.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign fifo_if.ovf_err = ovf_q;
  assign fifo_if.udf_err = udf_q;
`endif

endmodule : qam_fifo_arb_ctrl

// File: tb/tb_qam_fifo_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qam_fifo_arb_ctrl
//   Self-checking bench for qam_fifo_arb_ctrl. A small memory stands in for
//   fifo_mem. The reference model keeps the FIFO as a queue of symbols plus
//   the arbitration bookkeeping (locked owner, last winner) as plain integers.
//   Each cycle: inputs are driven just after posedge, combinational outputs
//   are compared mid-cycle, registered outputs are compared just after the
//   following posedge.
// -----------------------------------------------------------------------------
module tb_qam_fifo_arb_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int PTR_W  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst_n;

  qam_fifo_arb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) fifo_if ();

  qam_fifo_arb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fifo_if (fifo_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for fifo_mem: synchronous write, registered read data.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_out;

  always @(posedge clk) begin
    if (fifo_if.mem_wr_en) mem[fifo_if.mem_wr_ptr[ADDR_W-1:0]] <= fifo_if.mem_wr_data;
    if (fifo_if.mem_rd_en) data_out <= mem[fifo_if.mem_rd_ptr[ADDR_W-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Counters and reference model state
  // ---------------------------------------------------------------------------
  int vectors;
  int miscompares;

  logic [DATA_W-1:0] model_q[$];
  int                lock_owner;   // -1: none, else producer index
  int                last_winner;  // producer that won the last free pick
  int                push_total;
  int                pop_total;
  bit                m_ovf;
  bit                m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    lock_owner  = -1;
    last_winner = 1;
    push_total  = 0;
    pop_total   = 0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
  endtask

  task automatic drive(input bit v0, input bit l0, input logic [7:0] d0,
                       input bit v1, input bit l1, input logic [7:0] d1,
                       input bit pop);
    fifo_if.req0_valid = v0;
    fifo_if.req0_last  = l0;
    fifo_if.req0_data  = d0;
    fifo_if.req1_valid = v1;
    fifo_if.req1_last  = l1;
    fifo_if.req1_data  = d1;
    fifo_if.pop        = pop;
  endtask

  // One clock cycle: check combinational outputs against the model, clock,
  // advance the model, check registered outputs.
  task automatic tick();
    int                g;
    int                cnt;
    bit                m_full, m_empty, acc, pacc, ovf_set, udf_set, clr;
    bit                v[2];
    bit                l[2];
    logic [DATA_W-1:0] d[2];
    logic [DATA_W-1:0] exp_data;

    #2;
    v[0] = fifo_if.req0_valid; l[0] = fifo_if.req0_last; d[0] = fifo_if.req0_data;
    v[1] = fifo_if.req1_valid; l[1] = fifo_if.req1_last; d[1] = fifo_if.req1_data;

    cnt     = model_q.size();
    m_full  = (cnt == DEPTH);
    m_empty = (cnt == 0);

    if (lock_owner >= 0)       g = lock_owner;
    else if (v[0] && v[1])     g = 1 - last_winner;
    else if (v[0])             g = 0;
    else if (v[1])             g = 1;
    else                       g = -1;

    acc     = 1'b0;
    ovf_set = 1'b0;
    if (g >= 0) begin
      acc     = v[g] && !m_full;
      ovf_set = v[g] && m_full;
    end
    pacc    = fifo_if.pop && !m_empty;
    udf_set = fifo_if.pop && m_empty;

    check("owner",      fifo_if.owner,      (g < 0) ? 0 : (1 << g));
    check("req0_ready", fifo_if.req0_ready, (g == 0) && !m_full);
    check("req1_ready", fifo_if.req1_ready, (g == 1) && !m_full);
    check("mem_wr_en",  fifo_if.mem_wr_en,  acc);
    if (acc) check("mem_wr_data", fifo_if.mem_wr_data, d[g]);
    check("mem_rd_en",  fifo_if.mem_rd_en,  pacc);
    check("full",       fifo_if.full,       m_full);
    check("empty",      fifo_if.empty,      m_empty);
    check("level",      fifo_if.level,      cnt);
    check("mem_wr_ptr", fifo_if.mem_wr_ptr, push_total % (2 * DEPTH));
    check("mem_rd_ptr", fifo_if.mem_rd_ptr, pop_total % (2 * DEPTH));

`ifdef QAM_FIFO_ERR_FLAG_EN
    clr = fifo_if.err_clr;
`else
    clr = 1'b0;
`endif

    @(posedge clk);
    #1;

    exp_data = '0;
    if (pacc) begin
      exp_data = model_q.pop_front();
      pop_total++;
    end
    if (acc) begin
      model_q.push_back(d[g]);
      push_total++;
      if (lock_owner < 0) begin
        last_winner = g;
        if (!l[g]) lock_owner = g;
      end else if (l[g]) begin
        lock_owner = -1;
      end
    end
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_udf = udf_set ? 1'b1 : (clr ? 1'b0 : m_udf);

    check("pop_valid", fifo_if.pop_valid, pacc);
    if (pacc) check("data_out", data_out, exp_data);
`ifdef QAM_FIFO_ERR_FLAG_EN
    check("ovf_err", fifo_if.ovf_err, m_ovf);
    check("udf_err", fifo_if.udf_err, m_udf);
`endif
  endtask

  task automatic apply_reset();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
`ifdef QAM_FIFO_ERR_FLAG_EN
    fifo_if.err_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #2;
    check("rst_wr_ptr",    fifo_if.mem_wr_ptr, 0);
    check("rst_rd_ptr",    fifo_if.mem_rd_ptr, 0);
    check("rst_empty",     fifo_if.empty,      1);
    check("rst_full",      fifo_if.full,       0);
    check("rst_level",     fifo_if.level,      0);
    check("rst_pop_valid", fifo_if.pop_valid,  0);
    check("rst_owner",     fifo_if.owner,      0);
`ifdef QAM_FIFO_ERR_FLAG_EN
    check("rst_ovf_err",   fifo_if.ovf_err,    0);
    check("rst_udf_err",   fifo_if.udf_err,    0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n = 1'b0;
    #1;
    apply_reset();

    // 1: two single beats from producer 0, then two pops.
    drive(1, 1, 8'h11, 0, 0, 8'h00, 0); tick();
    drive(1, 1, 8'h22, 0, 0, 8'h00, 0); tick();
    check("t1_wr_ptr", fifo_if.mem_wr_ptr, 2);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    check("t1_first", data_out, 8'h11);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    check("t1_second", data_out, 8'h22);
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0); tick();
    check("t1_empty", fifo_if.empty, 1);

    // 2: both producers contend with single-beat bursts until full.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'hA0 + 8'(i), 1, 1, 8'hB0 + 8'(i), 0);
      tick();
    end
    check("t2_full",  fifo_if.full,  1);
    check("t2_level", fifo_if.level, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    end

    // 3: producer 0 wins once so producer 1 takes the next contention, then a
    // 3-beat producer-1 burst while producer 0 keeps asking.
    drive(1, 1, 8'h30, 0, 0, 8'h00, 0); tick();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    drive(1, 1, 8'h40, 1, 0, 8'h51, 0); tick();
    check("t3_owner_lock", fifo_if.owner, 2'b10);
    drive(1, 1, 8'h40, 1, 0, 8'h52, 0); tick();
    drive(1, 1, 8'h40, 1, 1, 8'h53, 0); tick();
    drive(1, 1, 8'h40, 0, 0, 8'h00, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    end

    // 4: fill, then push and pop together while full.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8'h60 + 8'(i), 0, 0, 8'h00, 0); tick();
    end
    drive(1, 1, 8'h64, 0, 0, 8'h00, 1); tick();
    check("t4_level_after_pop", fifo_if.level, 3);
    drive(1, 1, 8'h64, 0, 0, 8'h00, 0); tick();
    check("t4_level_refill", fifo_if.level, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    end

    // 5: pop while empty, alone and with a push.
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    drive(1, 1, 8'h77, 0, 0, 8'h00, 1); tick();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0); tick();
`ifdef QAM_FIFO_ERR_FLAG_EN
    fifo_if.err_clr = 1'b1; tick();
    fifo_if.err_clr = 1'b0;
`endif
    drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();

    // 6: six pushes interleaved with six pops across the pointer wrap, then a
    // reset in the middle of a locked burst.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 8'h80 + 8'(i), 0, 0, 8'h00, 0); tick();
      drive(0, 0, 8'h00, 0, 0, 8'h00, 1); tick();
    end
    drive(0, 0, 8'h00, 1, 0, 8'h91, 0); tick();
    drive(0, 0, 8'h00, 1, 0, 8'h92, 0); tick();
    apply_reset();
    drive(0, 0, 8'h00, 0, 0, 8'h00, 0); tick();

    // Randomized traffic: a push-heavy phase, a balanced phase and a
    // pop-heavy phase, with occasional flag clears.
    for (int i = 0; i < 450; i++) begin
      int pop_pct;
      pop_pct = (i < 150) ? 25 : ((i < 300) ? 50 : 75);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
            $urandom_range(0, 99) < pop_pct);
`ifdef QAM_FIFO_ERR_FLAG_EN
      fifo_if.err_clr = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_qam_fifo_arb_ctrl
